// File: rtl/bc_timing_control.sv
// ---------------------------------------------------------------------------
// bc_timing_control
//
// Sequence counter and timing/control generator for the Basic Computer.
// It takes the one-hot decoded opcode d[7:0] and the IR addressing-mode bit
// from upstream logic. From those it produces one-hot timing slots
// t[2**SC_WIDTH-1:0] and the fetch/decode/dispatch strobes that sequence the
// register datapath. It also owns the run/halt S flip-flop.
//
// Optional feature macro: SINGLE_STEP_EN
//   When defined, the input step_mode is added. With step_mode=1, an
//   accepted end-of-instruction (sc_clr) also halts the machine.
//
// Ports:
//   clk           rising-edge clock
//   rst_n         asynchronous active-low reset
//   start         level; starts execution when halted
//   hlt           HLT microop from execute logic
//   sc_clr        end-of-instruction; clears the sequence counter
//   step_mode     (SINGLE_STEP_EN only) halt after each instruction
//   d[7:0]        one-hot decoded opcode D0..D7
//   i_bit         IR[15] addressing-mode bit
//   t             one-hot timing slots, all zero when halted
//   sc            current sequence count
//   running       S flip-flop
//   fetch_ar_pc   T0 strobe  (AR<-PC)
//   fetch_ir_mem  T1 strobe  (IR<-M[AR], PC<-PC+1)
//   decode_en     T2 strobe  (decode IR, AR<-IR[11:0], latch I)
//   indirect      D7'.I.T3   (AR<-M[AR])
//   reg_ref       D7.I'.T3
//   io_ref        D7.I.T3
//   err_timeout   sticky: counter wrapped without sc_clr
//   err_decode    sticky: d not one-hot at T3 while running
//
// FETCH_LEN must be smaller than 2**SC_WIDTH. SC_WIDTH must be at least 2,
// so that the T3 dispatch slot exists.
// ---------------------------------------------------------------------------
module bc_timing_control #(
  parameter int SC_WIDTH  = 4,
  parameter int FETCH_LEN = 3
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       hlt,
  input  logic                       sc_clr,
`ifdef SINGLE_STEP_EN
  input  logic                       step_mode,
`endif
  input  logic [7:0]                 d,
  input  logic                       i_bit,
  output logic [(2**SC_WIDTH)-1:0]   t,
  output logic [SC_WIDTH-1:0]        sc,
  output logic                       running,
  output logic                       fetch_ar_pc,
  output logic                       fetch_ir_mem,
  output logic                       decode_en,
  output logic                       indirect,
  output logic                       reg_ref,
  output logic                       io_ref,
  output logic                       err_timeout,
  output logic                       err_decode
);

  localparam int                T_WIDTH    = 2**SC_WIDTH;
  localparam logic [SC_WIDTH-1:0] SC_FETCH = SC_WIDTH'(FETCH_LEN);
  localparam logic [SC_WIDTH-1:0] SC_LAST  = '1;
  // Slot in which the opcode is dispatched and d must be one-hot.
  localparam logic [SC_WIDTH-1:0] SC_DISPATCH = SC_WIDTH'(3);

  typedef enum logic {
    HALTED  = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t              state_reg;
  logic [SC_WIDTH-1:0] sc_reg;
  logic                err_timeout_reg;
  logic                err_decode_reg;

  logic                d_one_hot;
  logic                step_halt;

  // Exactly one bit set: nonzero, and clearing the lowest set bit leaves zero.
  assign d_one_hot = (d != 8'd0) && ((d & (d - 8'd1)) == 8'd0);

`ifdef SINGLE_STEP_EN
  assign step_halt = step_mode;
`else
  assign step_halt = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= HALTED;
      sc_reg          <= '0;
      err_timeout_reg <= 1'b0;
      err_decode_reg  <= 1'b0;
    end else begin
      case (state_reg)
        HALTED: begin
          // hlt and sc_clr have no meaning while halted; only start matters.
          sc_reg <= '0;
          if (start) begin
            state_reg <= RUNNING;
          end
        end
        RUNNING: begin
          // The decode check is independent of what the same edge does
          // to the counter (a halt at T3 still records a bad opcode).
          if (sc_reg == SC_DISPATCH && !d_one_hot) begin
            err_decode_reg <= 1'b1;
          end
          if (hlt) begin
            state_reg <= HALTED;
            sc_reg    <= '0;
          end else if (sc_clr && sc_reg >= SC_FETCH) begin
            // End of instruction. An sc_clr during the fetch slots falls
            // through to the increment, so fetch cannot be aborted.
            sc_reg <= '0;
            if (step_halt) begin
              state_reg <= HALTED;
            end
          end else if (sc_reg == SC_LAST) begin
            // Instruction never signalled its end. Restart from T0 and flag it.
            sc_reg          <= '0;
            err_timeout_reg <= 1'b1;
          end else begin
            sc_reg <= sc_reg + 1'b1;
          end
        end
        default: begin
          state_reg <= HALTED;
          sc_reg    <= '0;
        end
      endcase
    end
  end

  assign running     = (state_reg == RUNNING);
  assign sc          = sc_reg;
  assign err_timeout = err_timeout_reg;
  assign err_decode  = err_decode_reg;

  // One-hot slot decode. Gating by running keeps t at zero while halted.
  genvar gi;
  generate
    for (gi = 0; gi < T_WIDTH; gi++) begin : g_slot
      assign t[gi] = running && (sc_reg == SC_WIDTH'(gi));
    end
  endgenerate

  assign fetch_ar_pc  = t[0];
  assign fetch_ir_mem = t[1];
  assign decode_en    = t[2];
  assign indirect     = t[3] & ~d[7] &  i_bit;
  assign reg_ref      = t[3] &  d[7] & ~i_bit;
  assign io_ref       = t[3] &  d[7] &  i_bit;

endmodule

// File: tb/tb_bc_timing_control.sv
// ---------------------------------------------------------------------------
// tb_bc_timing_control
//
// Scoreboard bench for bc_timing_control.
// A stimulus process drives each cycle's inputs. It asks a behavioural
// model what the outputs must be during that cycle and queues that
// expectation. It then advances the model across the clock edge.
// A separate monitor process samples the DUT on the falling edge, pops the
// next expectation and compares the two.
// Compile with +define+SINGLE_STEP_EN to exercise the single-step port.
// ---------------------------------------------------------------------------
module tb_bc_timing_control;

  localparam int SCW = 4;
  localparam int FL  = 3;
  localparam int TW  = 2**SCW;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start, hlt, sc_clr, i_bit;
  logic [7:0]     d;
`ifdef SINGLE_STEP_EN
  logic           step_mode;
`endif
  logic [TW-1:0]  t;
  logic [SCW-1:0] sc;
  logic running, fetch_ar_pc, fetch_ir_mem, decode_en;
  logic indirect, reg_ref, io_ref, err_timeout, err_decode;

  bc_timing_control #(.SC_WIDTH(SCW), .FETCH_LEN(FL)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .hlt          (hlt),
    .sc_clr       (sc_clr),
`ifdef SINGLE_STEP_EN
    .step_mode    (step_mode),
`endif
    .d            (d),
    .i_bit        (i_bit),
    .t            (t),
    .sc           (sc),
    .running      (running),
    .fetch_ar_pc  (fetch_ar_pc),
    .fetch_ir_mem (fetch_ir_mem),
    .decode_en    (decode_en),
    .indirect     (indirect),
    .reg_ref      (reg_ref),
    .io_ref       (io_ref),
    .err_timeout  (err_timeout),
    .err_decode   (err_decode)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [TW-1:0]  t;
    logic [SCW-1:0] sc;
    logic running, fetch_ar_pc, fetch_ir_mem, decode_en;
    logic indirect, reg_ref, io_ref, err_timeout, err_decode;
  } obs_t;

  obs_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  bit   stim_done  = 0;

  // ---------------- behavioural reference model ----------------
  // The state is "is the machine running" plus "which slot it is in".
  bit m_run;
  int m_slot;
  bit m_errt, m_errd;

  function automatic int ones(input logic [7:0] v);
    int n = 0;
    for (int k = 0; k < 8; k++) if (v[k]) n++;
    return n;
  endfunction

  function automatic obs_t predict();
    obs_t o;
    bit   disp;
    o = '0;
    o.running = m_run;
    o.sc = SCW'(m_slot);
    if (m_run) o.t = TW'(1) << m_slot;
    o.fetch_ar_pc  = m_run && m_slot == 0;
    o.fetch_ir_mem = m_run && m_slot == 1;
    o.decode_en    = m_run && m_slot == 2;
    disp = m_run && m_slot == 3;
    o.indirect = disp && !d[7] &&  i_bit;
    o.reg_ref  = disp &&  d[7] && !i_bit;
    o.io_ref   = disp &&  d[7] &&  i_bit;
    o.err_timeout = m_errt;
    o.err_decode  = m_errd;
    return o;
  endfunction

  task automatic model_reset();
    m_run = 0; m_slot = 0; m_errt = 0; m_errd = 0;
  endtask

  // Apply the rules for one clock edge using the inputs currently driven.
  task automatic model_edge();
    bit single;
    single = 0;
`ifdef SINGLE_STEP_EN
    single = step_mode;
`endif
    if (!rst_n) begin
      model_reset();
    end else if (!m_run) begin
      if (start) m_run = 1;
      m_slot = 0;
    end else begin
      if (m_slot == 3 && ones(d) != 1) m_errd = 1;
      if (hlt) begin
        m_run = 0; m_slot = 0;
      end else if (sc_clr && m_slot >= FL) begin
        m_slot = 0;
        if (single) m_run = 0;
      end else if (m_slot == TW - 1) begin
        m_slot = 0; m_errt = 1;
      end else begin
        m_slot++;
      end
    end
  endtask

  // One cycle: drive inputs, queue the expected outputs, cross the edge.
  task automatic cyc(input bit st, input bit h, input bit c,
                     input logic [7:0] dv, input bit ib);
    start = st; hlt = h; sc_clr = c; d = dv; i_bit = ib;
    exp_q.push_back(predict());
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Pull rst_n low in the middle of a cycle; outputs must clear at once.
  task automatic mid_reset();
    #2;
    rst_n = 1'b0;
    model_reset();
    exp_q.push_back(predict());
    @(negedge clk);
    #2;
    start = 0; hlt = 0; sc_clr = 0;
    rst_n = 1'b1;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      obs_t act, exp_v;
      exp_v = exp_q.pop_front();
      act.t = t; act.sc = sc; act.running = running;
      act.fetch_ar_pc = fetch_ar_pc; act.fetch_ir_mem = fetch_ir_mem;
      act.decode_en = decode_en; act.indirect = indirect;
      act.reg_ref = reg_ref; act.io_ref = io_ref;
      act.err_timeout = err_timeout; act.err_decode = err_decode;
      vectors++;
      if (act !== exp_v) begin
        miscompares++;
        $display("FAIL vec %0d outputs: got t=%h sc=%0d run=%b str=%b%b%b%b%b%b err=%b%b, want t=%h sc=%0d run=%b str=%b%b%b%b%b%b err=%b%b",
                 vectors, act.t, act.sc, act.running, act.fetch_ar_pc,
                 act.fetch_ir_mem, act.decode_en, act.indirect, act.reg_ref,
                 act.io_ref, act.err_timeout, act.err_decode,
                 exp_v.t, exp_v.sc, exp_v.running, exp_v.fetch_ar_pc,
                 exp_v.fetch_ir_mem, exp_v.decode_en, exp_v.indirect,
                 exp_v.reg_ref, exp_v.io_ref, exp_v.err_timeout,
                 exp_v.err_decode);
      end else begin
        $display("vec %0d ok: t=%h sc=%0d run=%b err=%b%b",
                 vectors, act.t, act.sc, act.running, act.err_timeout,
                 act.err_decode);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0; start = 0; hlt = 0; sc_clr = 0; d = 8'h01; i_bit = 0;
`ifdef SINGLE_STEP_EN
    step_mode = 0;
`endif
    model_reset();
    @(posedge clk); #1;
    cyc(0, 0, 0, 8'h01, 0);                 // reset state
    rst_n = 1'b1;

    // Start, then the three fetch/decode slots.
    cyc(1, 0, 0, 8'h01, 0);
    cyc(0, 0, 0, 8'h01, 0);                 // T0
    cyc(0, 0, 0, 8'h01, 0);                 // T1
    cyc(0, 0, 0, 8'h01, 0);                 // T2
    // Memory-reference indirect, end at T4.
    cyc(0, 0, 0, 8'h04, 1);                 // T3 indirect
    cyc(0, 0, 1, 8'h04, 1);                 // T4 sc_clr
    // Register reference at T3 with sc_clr.
    cyc(0, 0, 0, 8'h80, 0);
    cyc(0, 0, 0, 8'h80, 0);
    cyc(0, 0, 0, 8'h80, 0);
    cyc(0, 0, 1, 8'h80, 0);                 // T3 reg_ref
    // I/O reference.
    cyc(0, 0, 0, 8'h80, 1);
    cyc(0, 0, 0, 8'h80, 1);
    cyc(0, 0, 0, 8'h80, 1);
    cyc(0, 0, 1, 8'h80, 1);                 // T3 io_ref
    // sc_clr during fetch is ignored; hlt at T5; sc_clr when halted.
    cyc(0, 0, 0, 8'h02, 0);                 // T0
    cyc(0, 0, 1, 8'h02, 0);                 // T1 with sc_clr
    for (int k = 2; k <= 4; k++) cyc(0, 0, 0, 8'h02, 0);
    cyc(0, 1, 0, 8'h02, 0);                 // T5 hlt
    cyc(0, 0, 1, 8'h02, 0);                 // halted, sc_clr ignored
    cyc(0, 0, 0, 8'h02, 0);
    // Start with hlt at the same edge: start wins.
    cyc(1, 1, 0, 8'h02, 0);
    // Run 17+ cycles without sc_clr and a bad opcode at T3.
    for (int k = 0; k < 18; k++) cyc(0, 0, 0, 8'h00, 0);
    cyc(0, 0, 0, 8'h10, 0);
    mid_reset();
    cyc(0, 0, 0, 8'h10, 0);

`ifdef SINGLE_STEP_EN
    step_mode = 1;
    cyc(1, 0, 0, 8'h01, 0);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 8'h01, 0);
    cyc(0, 0, 1, 8'h01, 0);                 // T4 sc_clr halts
    cyc(0, 0, 0, 8'h01, 0);
    cyc(1, 0, 0, 8'h01, 0);                 // re-arm
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 8'h01, 0);
    cyc(0, 0, 0, 8'h80, 1);                 // T3
    mid_reset();
    step_mode = 0;
`endif

    // Randomised run.
    for (int k = 0; k < 400; k++) begin
      logic [7:0] dv;
      if ($urandom_range(0, 9) == 0) dv = 8'($urandom);
      else dv = 8'(1) << $urandom_range(0, 7);
`ifdef SINGLE_STEP_EN
      step_mode = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 149) == 0) begin
        mid_reset();
      end else begin
        cyc($urandom_range(0, 3) == 0, $urandom_range(0, 39) == 0,
            $urandom_range(0, 2) == 0, dv, 1'($urandom));
      end
    end

    stim_done = 1;
    for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
    #1;
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: got %0d expectations left, want 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/bc_timing_control.md
Name: bc_timing_control

Overview:
Sequence counter and timing/control generator for the Basic Computer. Sits after the 3-to-8 opcode decoder:
- consumes its one-hot D[7:0] and the IR indirect bit;
- produces one-hot timing T[15:0] and the fetch/decode/dispatch strobes that sequence the register datapath;
- owns the run/halt S flip-flop.

Parameters:
SC_WIDTH, 4, sequence counter width; T output width is 2**SC_WIDTH
FETCH_LEN, 3, number of uninterruptible fetch/decode slots (T0..T(FETCH_LEN-1)); must be < 2**SC_WIDTH

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  level; starts execution when halted
hlt  in  1  HLT microop asserted by execute logic
sc_clr  in  1  end-of-instruction; clear sequence counter
d  in  8  one-hot decoded opcode D0..D7 from the opcode decoder
i_bit  in  1  IR[15] addressing-mode bit
t  out  2**SC_WIDTH  one-hot timing signals; all zero when halted
sc  out  SC_WIDTH  current sequence count
running  out  1  S flip-flop
fetch_ar_pc  out  1  T0 strobe (AR<-PC)
fetch_ir_mem  out  1  T1 strobe (IR<-M[AR], PC<-PC+1)
decode_en  out  1  T2 strobe (decode IR, AR<-IR[11:0], latch I)
indirect  out  1  D7'·I·T3 (AR<-M[AR])
reg_ref  out  1  D7·I'·T3
io_ref  out  1  D7·I·T3
err_timeout  out  1  sticky; SC wrapped without sc_clr
err_decode  out  1  sticky; d not one-hot at T3 while running

Behaviour:
- Reset (rst_n=0, async): running=0, sc=0, err_timeout=0, err_decode=0. All combinational outputs are therefore 0.
- Timing outputs:
  - t = one-hot decode of sc, gated by running.
  - Strobes are combinational from t, d and i_bit; zero-cycle latency relative to sc.
- Halted (running=0):
  - sc held at 0; hlt and sc_clr are ignored.
  - start=1 at a clock edge sets running=1 and keeps sc=0, so T0 is asserted in the following cycle.
- Running, next-state priority per edge:
  1. hlt=1: running<=0, sc<=0. Takes effect in any slot, including fetch.
  2. sc_clr=1 and sc>=FETCH_LEN: sc<=0, next cycle is T0.
  3. sc_clr=1 and sc<FETCH_LEN: ignored; sc increments (fetch cannot be aborted).
  4. Otherwise sc<=sc+1.
- start while running: ignored.
- Wrap: sc = 2**SC_WIDTH-1 with no sc_clr and no hlt gives sc<=0 and err_timeout<=1 (sticky until reset). Execution continues from T0.
- err_decode: set at the edge if running, sc==3, and d is zero or has more than one bit set. Sticky. The indirect/reg_ref/io_ref strobes still follow the d7 bit as given.
- Simultaneous start and hlt while halted: start wins (hlt is ignored when halted).
- Reset mid-instruction: immediate return to the reset state; no strobe glitches beyond the async clear.

Optional Feature:
SINGLE_STEP_EN
- Defined:
  - Adds input port step_mode (1 bit).
  - When step_mode=1 and an accepted sc_clr occurs (sc>=FETCH_LEN), the same edge also clears running. The machine halts after exactly one instruction; start re-arms it.
  - hlt priority is unchanged.
- Undefined: port absent; sc_clr never affects running.

Test Plan:
1. Reset then start=1 for one cycle -> running=1; t=0x0001, fetch_ar_pc=1; next cycles t=0x0002 (fetch_ir_mem=1) then 0x0004 (decode_en=1).
2. Running, d=8'h04, i_bit=1 at T3, sc_clr at T4 -> indirect=1 at sc=3, reg_ref=io_ref=0; sc returns to 0 and t=0x0001 the cycle after T4.
3. d=8'h80, i_bit=0 at T3 plus sc_clr -> reg_ref=1, sc=0 next cycle. Repeat with i_bit=1 -> io_ref=1.
4. sc_clr held at T1 -> ignored (sc=2 next). hlt at T5 -> running=0, t=0x0000, sc=0; a subsequent sc_clr pulse has no effect.
5. Running with no sc_clr for 16 cycles -> sc goes 15 then 0, err_timeout=1 and stays 1. d=8'h00 at T3 -> err_decode=1.
6. SINGLE_STEP_EN, step_mode=1:
   - start, then sc_clr at T4 -> running=0 after that edge, sc=0.
   - start again -> T0 the next cycle.
   - rst_n pulled low mid-T3 -> all outputs 0 immediately.
